// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, opcode constants and opcode decode for the load/store unit
package lsu_pkg;

    // MIPS primary opcodes handled by the load/store unit
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } mem_size_t;

    typedef struct packed {
        logic      legal;
        logic      is_store;
        logic      is_signed;
        mem_size_t size;
    } op_info_t;

    // Illegal opcodes decode as byte-sized so they never look misaligned;
    // the legal flag alone sends them to the error path.
    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{legal: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SIZE_BYTE};
        case (op)
            OP_LB:   begin info.is_signed = 1'b1; info.size = SIZE_BYTE; end
            OP_LH:   begin info.is_signed = 1'b1; info.size = SIZE_HALF; end
            OP_LW:   info.size = SIZE_WORD;
            OP_LBU:  info.size = SIZE_BYTE;
            OP_LHU:  info.size = SIZE_HALF;
            OP_SB:   begin info.is_store = 1'b1; info.size = SIZE_BYTE; end
            OP_SH:   begin info.is_store = 1'b1; info.size = SIZE_HALF; end
            OP_SW:   begin info.is_store = 1'b1; info.size = SIZE_WORD; end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, load extraction/extension, alignment check
module lsu_align
    import lsu_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_signed,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lane enables and replicated store data
    always_comb begin
        wmask = 4'hF;
        wdata = store_data;
        case (size)
            SIZE_BYTE: begin
                wmask = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                wmask = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wmask = 4'hF;
                wdata = store_data;
            end
        endcase
    end

    // Pick the addressed lane out of the loaded word and extend it
    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   load_data = rdata;
        endcase
    end

    // Halfwords need an even address, words need a multiple of four
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF: misaligned = offset[0];
            SIZE_WORD: misaligned = |offset;
            default:   misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM driving the data-memory request/grant/response handshake
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_idx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_idx,
    output logic [31:0] wb_data,
    output logic        addr_err,
    output logic [31:0] bad_vaddr
);

    lsu_state_t  state, state_nx;
    op_info_t    info;

    logic        we_q, signed_q;
    mem_size_t   size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, wb_data_q, bad_vaddr_q;
    logic [3:0]  wmask_q;
    logic [4:0]  idx_q;

    mem_size_t   al_size;
    logic        al_signed;
    logic [1:0]  al_off;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata, al_load;
    logic        al_misaligned;
    logic        accept_ok, accept_err;

    assign info = decode_op(opcode);

    // The aligner sees the live instruction while idle and the captured one afterwards
    always_comb begin
        al_size   = size_q;
        al_signed = signed_q;
        al_off    = off_q;
        if (state == ST_IDLE) begin
            al_size   = info.size;
            al_signed = info.is_signed;
            al_off    = addr[1:0];
        end
    end

    lsu_align u_align (
        .size       (al_size),
        .is_signed  (al_signed),
        .offset     (al_off),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    assign accept_ok  = (state == ST_IDLE) && valid_in && info.legal && !al_misaligned;
    assign accept_err = (state == ST_IDLE) && valid_in && (!info.legal || al_misaligned);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept_ok)       state_nx = ST_REQ;
                else if (accept_err) state_nx = ST_ERR;
            end
            ST_REQ:  if (mem_gnt) state_nx = we_q ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Capture the accepted request, the load result and the faulting address
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SIZE_BYTE;
            off_q       <= 2'd0;
            addr_q      <= 32'd0;
            wmask_q     <= 4'd0;
            wdata_q     <= 32'd0;
            idx_q       <= 5'd0;
            wb_data_q   <= 32'd0;
            bad_vaddr_q <= 32'd0;
        end else begin
            if (accept_ok) begin
                we_q     <= info.is_store;
                signed_q <= info.is_signed;
                size_q   <= info.size;
                off_q    <= addr[1:0];
                addr_q   <= {addr[31:2], 2'b00};
                wmask_q  <= info.is_store ? al_wmask : 4'd0;
                wdata_q  <= al_wdata;
                idx_q    <= rd_idx;
            end
            if (accept_err) bad_vaddr_q <= addr;
            if ((state == ST_WAIT) && mem_rvalid) wb_data_q <= al_load;
        end
    end

    // Outputs: memory signals only while requesting, strobes from state
    always_comb begin
        ready_out = (state == ST_IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wmask = 4'd0;
        mem_wdata = 32'd0;
        wb_valid  = (state == ST_RESP);
        addr_err  = (state == ST_ERR);
        wb_idx    = idx_q;
        wb_data   = wb_data_q;
        bad_vaddr = bad_vaddr_q;
        if (state == ST_REQ) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wmask = wmask_q;
            mem_wdata = wdata_q;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard bench for the load/store unit
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_idx;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        addr_err;
    logic [31:0] bad_vaddr;

    int checks = 0;
    int errors = 0;
    int wb_pulses = 0;
    int loads_expected = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .rd_idx     (rd_idx),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .addr_err   (addr_err),
        .bad_vaddr  (bad_vaddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wb_valid) wb_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] rdat);
        logic [31:0] sh;
        sh = rdat >> (8 * int'(off));
        case (op)
            6'h20:   return {{24{sh[7]}}, sh[7:0]};
            6'h21:   return {{16{sh[15]}}, sh[15:0]};
            6'h24:   return {24'd0, sh[7:0]};
            6'h25:   return {16'd0, sh[15:0]};
            default: return rdat;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [5:0] op, input logic [1:0] off);
        case (op)
            6'h28:   return 4'(1 << off);
            6'h29:   return 4'(3 << off);
            6'h2B:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] sd);
        case (op)
            6'h28:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            6'h29:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    // Called just after a rising edge; returns just after a rising edge with the LSU idle
    task automatic access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input int gnt_delay, input int rv_delay,
                          input logic [31:0] rdat);
        logic is_store, is_load, bad;
        req_t r;
        wb_t  w;
        int   pulses0;
        is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        is_load  = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
        bad = !(is_store || is_load)
           || (((op == 6'h21) || (op == 6'h25) || (op == 6'h29)) && a[0])
           || (((op == 6'h23) || (op == 6'h2B)) && (a[1:0] != 2'b00));
        pulses0 = wb_pulses;

        chk("ready_before_accept", 32'(ready_out), 32'd1);
        valid_in = 1'b1; opcode = op; addr = a; store_data = sd; rd_idx = rd;
        if (!bad) begin
            req_q.push_back('{we: is_store, addr: {a[31:2], 2'b00},
                              mask: model_mask(op, a[1:0]), wdata: model_wdata(op, sd)});
            if (is_load) begin
                wb_q.push_back('{idx: rd, data: model_load(op, a[1:0], rdat)});
                loads_expected++;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0; opcode = $urandom; addr = $urandom; store_data = $urandom;

        if (bad) begin
            @(negedge clk);
            chk("err_pulse", 32'(addr_err), 32'd1);
            chk("err_bad_vaddr", bad_vaddr, a);
            chk("err_no_req", 32'(mem_req), 32'd0);
            chk("err_ready_low", 32'(ready_out), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err_pulse_end", 32'(addr_err), 32'd0);
            chk("err_bad_vaddr_held", bad_vaddr, a);
            chk("err_ready_back", 32'(ready_out), 32'd1);
            chk("err_no_wb", 32'(wb_pulses), 32'(pulses0));
            @(posedge clk); #1;
            return;
        end

        r = req_q.pop_front();
        for (int i = 0; i <= gnt_delay; i++) begin
            mem_gnt    = (i == gnt_delay);
            mem_rvalid = (i != gnt_delay);
            mem_rdata  = $urandom;
            @(negedge clk);
            chk("req_valid", 32'(mem_req), 32'd1);
            chk("req_we", 32'(mem_we), 32'(r.we));
            chk("req_addr", mem_addr, r.addr);
            chk("req_wmask", 32'(mem_wmask), 32'(r.mask));
            if (r.we) chk("req_wdata", mem_wdata, r.wdata);
            chk("req_ready_low", 32'(ready_out), 32'd0);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        if (is_store) begin
            @(negedge clk);
            chk("store_ready_back", 32'(ready_out), 32'd1);
            chk("store_req_done", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            return;
        end

        for (int i = 0; i < rv_delay; i++) begin
            @(negedge clk);
            chk("wait_no_req", 32'(mem_req), 32'd0);
            chk("wait_ready_low", 32'(ready_out), 32'd0);
            chk("wait_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        chk("rvalid_ready_low", 32'(ready_out), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        chk("wb_strobe", 32'(wb_valid), 32'd1);
        if (wb_q.size() == 0) begin
            chk("wb_queue_nonempty", 32'd0, 32'd1);
        end else begin
            w = wb_q.pop_front();
            chk("wb_idx", 32'(wb_idx), 32'(w.idx));
            chk("wb_data", wb_data, w.data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("wb_strobe_end", 32'(wb_valid), 32'd0);
        chk("load_ready_back", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses0;
        rst = 1'b1; valid_in = 1'b0; opcode = 6'd0; addr = 32'd0; store_data = 32'd0;
        rd_idx = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_idx", 32'(wb_idx), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_bad_vaddr", bad_vaddr, 32'd0);
        @(posedge clk); #1;

        access(6'h2B, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
        access(6'h28, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 0, 32'd0);
        access(6'h29, 32'h0000_0102, 32'h1234_ABCD, 5'd0, 1, 0, 32'd0);
        access(6'h28, 32'h0000_0101, 32'h0000_773C, 5'd0, 0, 0, 32'd0);
        access(6'h20, 32'h0000_0102, 32'd0, 5'd8, 0, 0, 32'h12F0_3456);
        access(6'h24, 32'h0000_0102, 32'd0, 5'd8, 0, 0, 32'h12F0_3456);
        access(6'h21, 32'h0000_0102, 32'd0, 5'd3, 0, 1, 32'h8001_7F00);
        access(6'h25, 32'h0000_0102, 32'd0, 5'd4, 0, 0, 32'h8001_7F00);
        access(6'h21, 32'h0000_0200, 32'd0, 5'd5, 0, 0, 32'h0000_7FFF);
        access(6'h20, 32'h0000_0301, 32'd0, 5'd6, 0, 0, 32'hAA55_80CC);
        access(6'h23, 32'h0000_0104, 32'd0, 5'd31, 3, 2, 32'hCAFE_F00D);
        access(6'h21, 32'h0000_0101, 32'd0, 5'd9, 0, 0, 32'd0);
        access(6'h23, 32'h0000_0102, 32'd0, 5'd9, 0, 0, 32'd0);
        access(6'h2B, 32'h0000_0401, 32'h1111_1111, 5'd0, 0, 0, 32'd0);
        access(6'h22, 32'h0000_0500, 32'd0, 5'd9, 0, 0, 32'd0);

        // Reset while waiting for a load response; the late response must be dropped
        pulses0 = wb_pulses;
        valid_in = 1'b1; opcode = 6'h23; addr = 32'h0000_0200; rd_idx = 5'd7;
        @(posedge clk); #1;
        valid_in = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("rstwait_in_wait", 32'(ready_out), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rstwait_ready", 32'(ready_out), 32'd1);
        chk("rstwait_mem_req", 32'(mem_req), 32'd0);
        chk("rstwait_mem_addr", mem_addr, 32'd0);
        chk("rstwait_wb_valid", 32'(wb_valid), 32'd0);
        chk("rstwait_wb_idx", 32'(wb_idx), 32'd0);
        chk("rstwait_wb_data", wb_data, 32'd0);
        chk("rstwait_bad_vaddr", bad_vaddr, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstwait_no_wb", 32'(wb_pulses), 32'(pulses0));
        chk("rstwait_idle", 32'(ready_out), 32'd1);

        chk("wb_pulse_total", 32'(wb_pulses), 32'(loads_expected));
        chk("scoreboard_drained", 32'(req_q.size() + wb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
